// File: rtl/adsr_pkg.sv
// ---------------------------------------------------------------------------
// adsr_pkg
//   Shared types and helpers for the ADSR envelope stage.
//   - env_state_t : envelope phase encoding (also shown on the debug port)
//   - env_max()   : full-scale level for a given level width (ENV_MAX)
//   - sat_add()   : level increment that saturates at a ceiling
//   - sat_sub()   : level decrement that clamps at a floor
//   The arithmetic helpers work on 32-bit operands.
//   Callers pass levels no wider than 31 bits, so the sum or difference
//   never wraps before the saturation test is applied.
// ---------------------------------------------------------------------------
package adsr_pkg;

    localparam int STATE_W   = 3;
    localparam int ENV_W_DEF = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    // Full-scale envelope level (2^w - 1) for a level register of width w.
    function automatic logic [31:0] env_max(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // a + step, saturated to ceil.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] step,
                                            input logic [31:0] ceil);
        logic [31:0] sum;
        sum = a + step;
        return (sum > ceil) ? ceil : sum;
    endfunction

    // a - step, clamped to floor (never borrows below floor).
    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] step,
                                            input logic [31:0] floor);
        return (a < floor + step) ? floor : (a - step);
    endfunction

endpackage

// File: rtl/env_scale.sv
// ---------------------------------------------------------------------------
// env_scale
//   Registered amplitude scaler.
//   On a strobe it computes sample * level / 2^ENV_W and registers it.
//   The level is treated as unsigned and the division rounds toward minus
//   infinity (arithmetic shift).
//   valid_o is high for exactly the one cycle after each strobe.
//
//   Ports
//     Clk, Reset_n : clock, asynchronous active-low reset
//     strobe_i     : one-cycle sample strobe
//     sample_i     : signed input sample
//     level_i      : unsigned envelope level to apply
//     sample_o     : signed scaled sample (held between strobes)
//     valid_o      : pulse, sample_o was updated on the previous edge
// ---------------------------------------------------------------------------
module env_scale #(
    parameter int SAMPLE_W = 16,
    parameter int ENV_W    = 16
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       strobe_i,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic        [ENV_W-1:0]    level_i,
    output logic signed [SAMPLE_W-1:0] sample_o,
    output logic                       valid_o
);

    localparam int PROD_W = SAMPLE_W + ENV_W + 1;

    logic signed [PROD_W-1:0]   product;
    logic signed [SAMPLE_W-1:0] sample_d;
    logic signed [SAMPLE_W-1:0] sample_q;
    logic                       valid_q;

    // Zero-extend the level by one bit so the signed multiply treats it as
    // a non-negative magnitude.
    assign product  = PROD_W'(sample_i) * PROD_W'($signed({1'b0, level_i}));
    // Level < 2^ENV_W, so the shifted result always fits SAMPLE_W bits.
    assign sample_d = SAMPLE_W'(product >>> ENV_W);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= strobe_i;
            if (strobe_i) begin
                sample_q <= sample_d;
            end
        end
    end

    assign sample_o = sample_q;
    assign valid_o  = valid_q;

endmodule

// File: rtl/adsr_envelope.sv
// ---------------------------------------------------------------------------
// adsr_envelope
//   Per-voice ADSR amplitude envelope.
//   It sits between the wavetable synthesizer and the audio interface.
//   The envelope advances only on sample_strobe edges.
//   A rising gate at a strobe (re)starts ATTACK from the current level.
//   A low gate in ATTACK/DECAY/SUSTAIN enters RELEASE.
//   Otherwise the current phase keeps stepping toward its target.
//   The strobe that changes phase also applies the new phase's step.
//   The sample is scaled by the level held before the strobe's update.
//
//   Ports
//     Clk, Reset_n  : clock, asynchronous active-low reset
//     gate          : key held (synchronous to Clk)
//     sample_strobe : one-cycle pulse per audio sample
//     sample_in     : signed sample from the synthesizer
//     sample_out    : signed enveloped sample
//     out_valid     : pulse, sample_out updated
//     env_level     : current envelope level
//     state_out     : current envelope phase encoding
//     active        : voice is not IDLE
// ---------------------------------------------------------------------------
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int               SAMPLE_W      = 16,
    parameter int               ENV_W         = ENV_W_DEF,
    parameter logic [ENV_W-1:0] ATTACK_STEP   = ENV_W'(16'h0100),
    parameter logic [ENV_W-1:0] DECAY_STEP    = ENV_W'(16'h0040),
    parameter logic [ENV_W-1:0] SUSTAIN_LEVEL = ENV_W'(16'hC000),
    parameter logic [ENV_W-1:0] RELEASE_STEP  = ENV_W'(16'h0020)
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       gate,
    input  logic                       sample_strobe,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       out_valid,
    output logic        [ENV_W-1:0]    env_level,
    output logic        [STATE_W-1:0]  state_out,
    output logic                       active
);

    localparam logic [31:0]      LEVEL_MAX_W = env_max(ENV_W);
    localparam logic [ENV_W-1:0] LEVEL_MAX   = LEVEL_MAX_W[ENV_W-1:0];

    env_state_t       state_q, state_d;
    env_state_t       eff_state;
    logic [ENV_W-1:0] level_q, level_d;
    logic             gate_q;
    logic             rise;

    // Next-state / next-level.
    // eff_state is the phase this strobe acts in, after gate-driven
    // transitions are applied.
    always_comb begin
        rise      = gate & ~gate_q;
        eff_state = state_q;
        if (rise) begin
            eff_state = ST_ATTACK;
        end else if (!gate && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                               state_q == ST_SUSTAIN)) begin
            eff_state = ST_RELEASE;
        end

        state_d = state_q;
        level_d = level_q;
        if (sample_strobe) begin
            state_d = eff_state;
            case (eff_state)
                ST_IDLE: begin
                    level_d = '0;
                end
                ST_ATTACK: begin
                    // Starts from the current level, so a retrigger never clicks.
                    level_d = ENV_W'(sat_add(32'(level_q), 32'(ATTACK_STEP),
                                             LEVEL_MAX_W));
                    if (level_d == LEVEL_MAX) begin
                        state_d = ST_DECAY;
                    end
                end
                ST_DECAY: begin
                    level_d = ENV_W'(sat_sub(32'(level_q), 32'(DECAY_STEP),
                                             32'(SUSTAIN_LEVEL)));
                    if (level_d == SUSTAIN_LEVEL) begin
                        state_d = ST_SUSTAIN;
                    end
                end
                ST_SUSTAIN: begin
                    level_d = SUSTAIN_LEVEL;
                end
                ST_RELEASE: begin
                    level_d = ENV_W'(sat_sub(32'(level_q), 32'(RELEASE_STEP),
                                             32'd0));
                    if (level_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    level_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            if (sample_strobe) begin
                gate_q <= gate;
            end
        end
    end

    // Scales by level_q, the level before this strobe's update.
    env_scale #(
        .SAMPLE_W (SAMPLE_W),
        .ENV_W    (ENV_W)
    ) u_scale (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .strobe_i (sample_strobe),
        .sample_i (sample_in),
        .level_i  (level_q),
        .sample_o (sample_out),
        .valid_o  (out_valid)
    );

    assign env_level = level_q;
    assign state_out = state_q;
    assign active    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Testbench for adsr_envelope.
// A table-driven reference model supplies the expected level, phase and
// scaled sample for every strobe.
module tb_adsr_envelope;

    localparam int SW = 16;
    localparam int EW = 16;

    logic                 Clk = 1'b0;
    logic                 Reset_n = 1'b0;
    logic                 gate = 1'b0;
    logic                 sample_strobe = 1'b0;
    logic signed [SW-1:0] sample_in = '0;
    logic signed [SW-1:0] sample_out;
    logic                 out_valid;
    logic [EW-1:0]        env_level;
    logic [2:0]           state_out;
    logic                 active;

    adsr_envelope dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .gate          (gate),
        .sample_strobe (sample_strobe),
        .sample_in     (sample_in),
        .sample_out    (sample_out),
        .out_valid     (out_valid),
        .env_level     (env_level),
        .state_out     (state_out),
        .active        (active)
    );

    // ---------------- clock / watchdog ----------------
    always #10 Clk = ~Clk;

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Per phase: signed step per strobe, target level, phase entered once
    // the target is reached. Phases: 0 idle, 1 attack, 2 decay,
    // 3 sustain, 4 release.
    int m_step [5] = '{0, 256, -64, 0, -32};
    int m_limit[5] = '{0, 65535, 49152, 49152, 0};
    int m_after[5] = '{0, 2, 3, 3, 0};
    int m_level;
    int m_state;
    bit m_gate_prev;

    logic [SW-1:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        m_level     = 0;
        m_state     = 0;
        m_gate_prev = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit g, input logic signed [SW-1:0] s);
        longint prod;
        int     nxt;
        prod = longint'(s) * longint'(m_level);
        exp_q.push_back(SW'(prod >>> EW));
        if (g && !m_gate_prev)
            m_state = 1;
        else if (!g && m_state >= 1 && m_state <= 3)
            m_state = 4;
        nxt = m_level + m_step[m_state];
        if (m_step[m_state] > 0)
            m_level = (nxt > m_limit[m_state]) ? m_limit[m_state] : nxt;
        else
            m_level = (nxt < m_limit[m_state]) ? m_limit[m_state] : nxt;
        if (m_level == m_limit[m_state])
            m_state = m_after[m_state];
        m_gate_prev = g;
    endtask

    // ---------------- drivers ----------------
    task automatic apply_reset();
        @(negedge Clk);
        Reset_n       = 1'b0;
        gate          = 1'b0;
        sample_strobe = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
    endtask

    // Drives one strobe. It returns #1 after the strobe's clock edge.
    task automatic do_strobe(input bit g, input logic signed [SW-1:0] s);
        @(negedge Clk);
        gate          = g;
        sample_in     = s;
        sample_strobe = 1'b1;
        model_step(g, s);
        @(posedge Clk);
        #1;
        sample_strobe = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++;
        if (state_out !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d, expected 0", state_out); end
        n_checks++;
        if (env_level !== 16'h0000) begin n_fail++; $display("FAIL reset_level: got %h, expected 0000", env_level); end
        n_checks++;
        if (sample_out !== 16'sd0) begin n_fail++; $display("FAIL reset_sample_out: got %0d, expected 0", sample_out); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        n_checks++;
        if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b, expected 0", active); end
    endtask

    task automatic test_idle();
        logic [SW-1:0] e;
        for (int k = 0; k < 3; k++) begin
            repeat (1041) @(negedge Clk);
            do_strobe(1'b0, SW'($urandom));
            e = exp_q.pop_front();
            n_checks++;
            if (state_out !== 3'd0 || env_level !== 16'h0000 || sample_out !== 16'sd0 ||
                active !== 1'b0 || sample_out !== e) begin
                n_fail++;
                $display("FAIL idle_strobe %0d: state=%0d level=%h out=%0d active=%b, expected 0/0000/0/0",
                         k, state_out, env_level, sample_out, active);
            end
        end
    endtask

    task automatic test_attack();
        logic [SW-1:0] e;
        for (int i = 1; i <= 256; i++) begin
            do_strobe(1'b1, SW'($urandom));
            e = exp_q.pop_front();
            n_checks++;
            if (env_level !== m_level[15:0] || state_out !== m_state[2:0] || sample_out !== e) begin
                n_fail++;
                $display("FAIL attack_model strobe %0d: level=%h state=%0d out=%0d, expected level=%h state=%0d out=%0d",
                         i, env_level, state_out, sample_out, m_level[15:0], m_state, $signed(e));
            end
            if (i == 1) begin
                n_checks++;
                if (env_level !== 16'h0100 || state_out !== 3'd1) begin
                    n_fail++; $display("FAIL attack_first: level=%h state=%0d, expected 0100/1", env_level, state_out);
                end
            end
            if (i == 255) begin
                n_checks++;
                if (env_level !== 16'hFF00 || state_out !== 3'd1) begin
                    n_fail++; $display("FAIL attack_255: level=%h state=%0d, expected ff00/1", env_level, state_out);
                end
            end
            if (i == 256) begin
                n_checks++;
                if (env_level !== 16'hFFFF || state_out !== 3'd2) begin
                    n_fail++; $display("FAIL attack_peak: level=%h state=%0d, expected ffff/2", env_level, state_out);
                end
            end
        end
    endtask

    task automatic test_decay_sustain();
        logic [SW-1:0] e;
        for (int i = 1; i <= 1256; i++) begin
            do_strobe(1'b1, SW'($urandom));
            e = exp_q.pop_front();
            n_checks++;
            if (env_level !== m_level[15:0] || state_out !== m_state[2:0] || sample_out !== e) begin
                n_fail++;
                $display("FAIL decay_model strobe %0d: level=%h state=%0d out=%0d, expected level=%h state=%0d out=%0d",
                         i, env_level, state_out, sample_out, m_level[15:0], m_state, $signed(e));
            end
            if (i == 255) begin
                n_checks++;
                if (env_level !== 16'hC03F || state_out !== 3'd2) begin
                    n_fail++; $display("FAIL decay_255: level=%h state=%0d, expected c03f/2", env_level, state_out);
                end
            end
            if (i >= 256) begin
                n_checks++;
                if (env_level !== 16'hC000 || state_out !== 3'd3 || active !== 1'b1) begin
                    n_fail++; $display("FAIL sustain_hold strobe %0d: level=%h state=%0d, expected c000/3", i, env_level, state_out);
                end
            end
        end
    endtask

    task automatic test_release();
        logic [SW-1:0] e;
        for (int i = 1; i <= 1536; i++) begin
            do_strobe(1'b0, SW'($urandom));
            e = exp_q.pop_front();
            n_checks++;
            if (env_level !== m_level[15:0] || state_out !== m_state[2:0] || sample_out !== e) begin
                n_fail++;
                $display("FAIL release_model strobe %0d: level=%h state=%0d out=%0d, expected level=%h state=%0d out=%0d",
                         i, env_level, state_out, sample_out, m_level[15:0], m_state, $signed(e));
            end
            if (i == 1) begin
                n_checks++;
                if (env_level !== 16'hBFE0 || state_out !== 3'd4 || active !== 1'b1) begin
                    n_fail++; $display("FAIL release_first: level=%h state=%0d active=%b, expected bfe0/4/1", env_level, state_out, active);
                end
            end
            if (i == 1535) begin
                n_checks++;
                if (env_level !== 16'h0020 || state_out !== 3'd4) begin
                    n_fail++; $display("FAIL release_1535: level=%h state=%0d, expected 0020/4", env_level, state_out);
                end
            end
            if (i == 1536) begin
                n_checks++;
                if (env_level !== 16'h0000 || state_out !== 3'd0 || active !== 1'b0) begin
                    n_fail++; $display("FAIL release_end: level=%h state=%0d active=%b, expected 0000/0/0", env_level, state_out, active);
                end
            end
        end
    endtask

    task automatic test_retrigger();
        logic [SW-1:0] e;
        for (int i = 1; i <= 1024; i++) begin
            do_strobe(i <= 512, SW'($urandom));
            e = exp_q.pop_front();
            n_checks++;
            if (env_level !== m_level[15:0] || state_out !== m_state[2:0] || sample_out !== e) begin
                n_fail++;
                $display("FAIL retrig_model strobe %0d: level=%h state=%0d out=%0d, expected level=%h state=%0d out=%0d",
                         i, env_level, state_out, sample_out, m_level[15:0], m_state, $signed(e));
            end
        end
        n_checks++;
        if (env_level !== 16'h8000 || state_out !== 3'd4) begin
            n_fail++; $display("FAIL retrig_pre: level=%h state=%0d, expected 8000/4", env_level, state_out);
        end
        do_strobe(1'b1, 16'sd16384);
        e = exp_q.pop_front();
        n_checks++;
        if (env_level !== 16'h8100 || state_out !== 3'd1) begin
            n_fail++; $display("FAIL retrig_attack: level=%h state=%0d, expected 8100/1", env_level, state_out);
        end
        n_checks++;
        if (sample_out !== 16'sd8192 || out_valid !== 1'b1 || sample_out !== e) begin
            n_fail++; $display("FAIL retrig_scale: out=%0d valid=%b, expected 8192/1", sample_out, out_valid);
        end
    endtask

    // Ramps up with n attack strobes from reset, then strobes sample s and
    // checks the scaled result and the out_valid pulse.
    task automatic test_scaling();
        int                   ramp [3] = '{256, 256, 128};
        logic signed [SW-1:0] smp  [3] = '{16'sd32767, -16'sd32768, 16'sd16384};
        logic signed [SW-1:0] want [3] = '{16'sd32766, -16'sd32768, 16'sd8192};
        logic [SW-1:0]        e;
        for (int k = 0; k < 3; k++) begin
            apply_reset();
            for (int i = 0; i < ramp[k]; i++) begin
                do_strobe(1'b1, 16'sd0);
                e = exp_q.pop_front();
            end
            n_checks++;
            if (env_level !== m_level[15:0]) begin
                n_fail++; $display("FAIL scale_ramp %0d: level=%h, expected %h", k, env_level, m_level[15:0]);
            end
            do_strobe(1'b1, smp[k]);
            e = exp_q.pop_front();
            n_checks++;
            if (sample_out !== want[k] || out_valid !== 1'b1 || sample_out !== e) begin
                n_fail++;
                $display("FAIL scale_%0d: out=%0d valid=%b, expected out=%0d valid=1", k, sample_out, out_valid, want[k]);
            end
            @(posedge Clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b0 || sample_out !== want[k]) begin
                n_fail++;
                $display("FAIL scale_valid_drop_%0d: valid=%b out=%0d, expected valid=0 out=%0d", k, out_valid, sample_out, want[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [SW-1:0] e;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            do_strobe(1'b1, SW'($urandom_range(1000, 30000)));
            e = exp_q.pop_front();
        end
        n_checks++;
        if (env_level !== 16'h0A00 || state_out !== 3'd1 || out_valid !== 1'b1 || sample_out === 16'sd0) begin
            n_fail++;
            $display("FAIL areset_pre: level=%h state=%0d valid=%b out=%0d, expected 0a00/1/1/nonzero",
                     env_level, state_out, out_valid, sample_out);
        end
        #4;
        Reset_n = 1'b0;
        #1;
        n_checks++;
        if (env_level !== 16'h0000 || state_out !== 3'd0 || sample_out !== 16'sd0 ||
            out_valid !== 1'b0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: level=%h state=%0d out=%0d valid=%b active=%b, expected all 0",
                     env_level, state_out, sample_out, out_valid, active);
        end
        @(negedge Clk);
        gate    = 1'b0;
        Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        logic [SW-1:0] e;
        bit            g;
        int            len;
        int            gap;
        int            held;
        apply_reset();
        for (int seg = 0; seg < 14; seg++) begin
            g   = (seg % 2 == 0);
            len = (seg % 3 == 2) ? $urandom_range(1, 8) : $urandom_range(20, 450);
            for (int i = 0; i < len; i++) begin
                gap = $urandom_range(0, 3);
                held = m_level;
                for (int c = 0; c < gap; c++) begin
                    @(posedge Clk);
                    #1;
                    n_checks++;
                    if (out_valid !== 1'b0 || env_level !== held[15:0]) begin
                        n_fail++;
                        $display("FAIL rand_hold seg %0d: valid=%b level=%h, expected valid=0 level=%h",
                                 seg, out_valid, env_level, held[15:0]);
                    end
                end
                do_strobe(g, SW'($urandom));
                e = exp_q.pop_front();
                n_checks++;
                if (env_level !== m_level[15:0] || state_out !== m_state[2:0] || sample_out !== e ||
                    out_valid !== 1'b1 || active !== (m_state != 0)) begin
                    n_fail++;
                    $display("FAIL rand_strobe seg %0d: level=%h state=%0d out=%0d valid=%b, expected level=%h state=%0d out=%0d valid=1",
                             seg, env_level, state_out, sample_out, out_valid, m_level[15:0], m_state, $signed(e));
                end
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_attack();
        test_decay_sustain();
        test_release();
        test_retrigger();
        test_scaling();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
